// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
//   Shared definitions for the reset sequencer: phase encodings (also the
//   FSM state encoding) and small elaboration-time helpers.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        PH_SYNC    = 2'd0,
        PH_HOLD    = 2'd1,
        PH_RELEASE = 2'd2,
        PH_DONE    = 2'd3
    } phase_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index register width; a single domain still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync
//   Async-assert / sync-deassert reset synchronizer. Reusable standalone.
//   Ports:
//     clk  in  clock
//     rst  in  raw async active-high reset
//     srst out synchronized reset; rises immediately with rst, falls on the
//              SYNC_STAGES-th posedge after rst goes low
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic srst
);

    generate
        if (SYNC_STAGES < 2) begin : g_chk_stages
            $error("reset_sync: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Zeros shift in from bit 0; the MSB is the synchronized reset.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign srst = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns one raw async reset into N_DOMAINS sequenced active-high resets.
//   All outputs assert together; after synchronized release and a hold time
//   they release one by one (domain 0 first), then ready rises.
//   Ports:
//     clk         in   clock
//     rst         in   raw async active-high reset
//     sw_rst_req  in   sync request to rerun the sequence from HOLD
//     rst_out     out  [N_DOMAINS-1:0] domain resets, bit k released k-th
//     ready       out  all domains released
//     phase       out  [1:0] debug: 0 SYNC, 1 HOLD, 2 RELEASE, 3 DONE
module reset_sequencer #(
    parameter int N_DOMAINS   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst_req,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic [1:0]           phase
);

    import reset_sequencer_pkg::*;

    localparam int IDX_W = idx_width(N_DOMAINS);

    generate
        if (N_DOMAINS < 1) begin : g_chk_n
            $error("reset_sequencer: N_DOMAINS must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_chk_sync
            $error("reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_chk_hold
            $error("reset_sequencer: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_chk_gap
            $error("reset_sequencer: GAP_CYCLES must be >= 1");
        end
        if ((max2(HOLD_CYCLES, GAP_CYCLES) - 1) >= (1 << CNT_W)) begin : g_chk_cnt
            $error("reset_sequencer: CNT_W too small for HOLD_CYCLES/GAP_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

    logic srst;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
        .clk  (clk),
        .rst  (rst),
        .srst (srst)
    );

    phase_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                 ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;

        if (sw_rst_req && (state_q != PH_SYNC)) begin
            state_d   = PH_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                // The edge on which srst is first seen low already counts as
                // the first HOLD edge, so domain 0 falls exactly
                // SYNC_STAGES+HOLD_CYCLES edges after rst drops.
                PH_SYNC, PH_HOLD: begin
                    if ((state_q == PH_HOLD) || !srst) begin
                        if (cnt_q == HOLD_LAST) begin
                            rst_out_d[0] = 1'b0;
                            cnt_d        = '0;
                            idx_d        = IDX_W'(1);
                            state_d      = (N_DOMAINS > 1) ? PH_RELEASE : PH_DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = PH_HOLD;
                        end
                    end
                end
                PH_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_out_d[idx_q] = 1'b0;
                        cnt_d            = '0;
                        idx_d            = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = PH_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_DONE: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = PH_SYNC;
                end
            endcase
        end
    end

    // Raw rst clears these directly so the outputs assert with no clock.
    // Its deassertion needs no synchronizing here: the FSM sits in SYNC,
    // doing nothing, until srst (the synchronized copy) falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PH_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign phase   = state_q;

endmodule
